controle_busca: RTL and testbench
=================================

Name: controle_busca

Overview:
- Fetch sequencer that drives the write side of the 8-bit program-counter register: generates the next-PC value and its write strobe.
- Reads pc_atual from the PC output, fetches the instruction from instruction memory over a req/ack handshake, and presents it to the decoder on a valid/ready handshake.
- Updates the PC with pc+1 or a branch target taken from the decoder.
- Sits between the PC register, instruction memory and the control/decode unit.

Parameters:
- IW, 16, instruction width in bits.
- MAX_ESPERA, 15, maximum cycles waiting for mem_ack before a fetch error is flagged (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_atual  in  8  current PC value (PC register output).
- entrada_pc  out  8  next PC value (to PC data input).
- esc_pc  out  1  PC write enable, one-cycle pulse.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  8  instruction memory address.
- mem_ack  in  1  memory data valid, single-cycle.
- mem_dado  in  IW  memory read data, valid when mem_ack=1.
- instr  out  IW  fetched instruction.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decoder accepts instr.
- desvio  in  1  branch taken, qualified by instr_valid&&instr_ready.
- alvo_desvio  in  8  branch target, qualified the same way.
- halt  in  1  stop fetching at the next instruction boundary.
- erro_busca  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO; all outputs 0; internal registers (instr, mem_addr, wait counter, branch flag/target) cleared.
- States: OCIOSO, BUSCA, ENTREGA, ATUALIZA, ERRO.
- OCIOSO:
  - halt=0 -> BUSCA next cycle; latch mem_addr=pc_atual on that edge.
  - halt=1 -> stay.
- BUSCA:
  - mem_req=1, mem_addr held.
  - mem_ack=1 -> capture mem_dado into instr, go to ENTREGA, clear the wait counter. Zero-wait ack is legal (ack in the first BUSCA cycle).
  - Otherwise increment the wait counter. If the counter reaches MAX_ESPERA with no ack -> ERRO.
  - mem_ack outside BUSCA is ignored.
- ENTREGA:
  - instr_valid=1; instr stable until accepted.
  - On instr_ready=1, latch desvio and alvo_desvio, go to ATUALIZA.
  - desvio/alvo_desvio are ignored when instr_ready=0.
- ATUALIZA:
  - esc_pc=1 for exactly one cycle.
  - entrada_pc = branch flag ? alvo : pc_atual+1, mod 256 (0xFF+1 = 0x00, no carry out).
  - Next state: halt=1 -> OCIOSO; else BUSCA, with mem_addr loaded from entrada_pc on the same edge the PC updates.
- ERRO:
  - erro_busca=1; mem_req=0, esc_pc=0, instr_valid=0.
  - Only reset exits.
- Steady-state cost: one instruction per 3 cycles with zero-wait memory and an always-ready decoder (BUSCA, ENTREGA, ATUALIZA).
- esc_pc is never asserted outside ATUALIZA; entrada_pc holds its last value otherwise.
- halt is sampled only in OCIOSO and ATUALIZA; a halt raised mid-fetch completes the current instruction first.
- Asynchronous reset mid-operation aborts immediately: an outstanding mem_req drops and any pending ack is ignored. The PC register itself is not reset by this block.
- Branch target equal to the current PC is legal (self-loop).

Decomposition:
- Shared package: state enum estado_busca_t {OCIOSO, BUSCA, ENTREGA, ATUALIZA, ERRO}, PC_W=8, PC_INC=8'd1.
- Natural sub-module: contador_espera (saturating wait counter with clear/enable and an at-limit output), reusable by other memory-facing controllers.
- Everything else is one FSM plus datapath registers.

Test Plan:
- Reset release, halt=0, pc_atual=0x00, memory acks in the first BUSCA cycle, ready=1 -> mem_addr=0x00, instr_valid one cycle later, esc_pc pulse with entrada_pc=0x01, next mem_addr=0x01; 3 cycles per instruction.
- pc_atual=0xFF, no branch -> entrada_pc=0x00 on esc_pc, next mem_addr=0x00.
- Accept with desvio=1, alvo_desvio=0x3A -> entrada_pc=0x3A; a desvio pulse while instr_ready=0 is ignored (entrada_pc=pc+1).
- mem_ack delayed 4 cycles, then instr_ready delayed 3 cycles -> mem_req held 5 cycles; instr stable and valid until ready; exactly one esc_pc.
- No mem_ack for MAX_ESPERA=15 cycles -> erro_busca=1 and sticky, no esc_pc; assert reset -> erro_busca=0, state OCIOSO.
- halt raised during BUSCA -> the instruction completes with one esc_pc, then OCIOSO with mem_req=0; halt lowered -> fetch resumes at the updated PC.

Source files
------------

// File: rtl/controle_busca_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding
// and the next-PC rule used on every PC update.
package controle_busca_pkg;

    localparam int              PC_W   = 8;
    localparam logic [PC_W-1:0] PC_INC = 8'd1;

    typedef enum logic [2:0] {
        OCIOSO,
        BUSCA,
        ENTREGA,
        ATUALIZA,
        ERRO
    } estado_busca_t;

    // Branch target when taken, otherwise sequential; 8-bit add wraps 0xFF -> 0x00.
    function automatic logic [PC_W-1:0] proximo_pc(
        input logic            desvio,
        input logic [PC_W-1:0] alvo,
        input logic [PC_W-1:0] pc
    );
        return desvio ? alvo : (pc + PC_INC);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Saturating wait counter for memory-facing controllers. 'ultimo' is high
// when the next enabled increment brings the count to LIMITE.
module contador_espera #(
    parameter int LIMITE = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic ultimo
);

    localparam int            W      = $clog2(LIMITE + 1);
    localparam logic [W-1:0]  TETO   = W'(LIMITE);
    localparam logic [W-1:0]  PENULT = W'(LIMITE - 1);

    logic [W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (clr) begin
            valor <= '0;
        end else if (en && (valor != TETO)) begin
            valor <= valor + 1'b1;
        end
    end

    assign ultimo = (valor >= PENULT);

endmodule

// File: rtl/controle_busca.sv
// Fetch sequencer: reads the instruction at the current PC over req/ack,
// hands it to the decoder over valid/ready, then writes pc+1 or a branch target.
module controle_busca
    import controle_busca_pkg::*;
#(
    parameter int IW         = 16,
    parameter int MAX_ESPERA = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_atual,
    output logic [PC_W-1:0] entrada_pc,
    output logic            esc_pc,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [IW-1:0]   mem_dado,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            desvio,
    input  logic [PC_W-1:0] alvo_desvio,
    input  logic            halt,
    output logic            erro_busca
);

    estado_busca_t estado;
    logic          cnt_en;
    logic          cnt_clr;
    logic          cnt_ultimo;

    // Count only unanswered request cycles; any other cycle restarts the window.
    assign cnt_en  = (estado == BUSCA) && !mem_ack;
    assign cnt_clr = !cnt_en;

    contador_espera #(
        .LIMITE(MAX_ESPERA)
    ) u_espera (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .ultimo(cnt_ultimo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            entrada_pc  <= '0;
            esc_pc      <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            erro_busca  <= 1'b0;
        end else begin
            esc_pc <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (!halt) begin
                        mem_addr <= pc_atual;
                        mem_req  <= 1'b1;
                        estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        instr       <= mem_dado;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        estado      <= ENTREGA;
                    end else if (cnt_ultimo) begin
                        mem_req    <= 1'b0;
                        erro_busca <= 1'b1;
                        estado     <= ERRO;
                    end
                end
                ENTREGA: begin
                    // entrada_pc doubles as the latched branch decision for ATUALIZA.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        entrada_pc  <= proximo_pc(desvio, alvo_desvio, pc_atual);
                        esc_pc      <= 1'b1;
                        estado      <= ATUALIZA;
                    end
                end
                ATUALIZA: begin
                    if (halt) begin
                        estado <= OCIOSO;
                    end else begin
                        mem_addr <= entrada_pc;
                        mem_req  <= 1'b1;
                        estado   <= BUSCA;
                    end
                end
                ERRO: begin
                    estado <= ERRO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: models the PC register and memory/decoder
// handshakes, checking each instruction against the next-PC rule.
module tb_controle_busca;

    logic        clock;
    logic        reset;
    logic [7:0]  pc_atual;
    logic [7:0]  entrada_pc;
    logic        esc_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_dado;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        desvio;
    logic [7:0]  alvo_desvio;
    logic        halt;
    logic        erro_busca;

    controle_busca #(.IW(16), .MAX_ESPERA(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_atual   (pc_atual),
        .entrada_pc (entrada_pc),
        .esc_pc     (esc_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_dado   (mem_dado),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .desvio     (desvio),
        .alvo_desvio(alvo_desvio),
        .halt       (halt),
        .erro_busca (erro_busca)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External PC register: not reset by the sequencer, loadable by the bench.
    logic       pc_load;
    logic [7:0] pc_load_val;
    always @(posedge clock) begin
        if (pc_load)     pc_atual <= pc_load_val;
        else if (esc_pc) pc_atual <= entrada_pc;
    end

    int esc_count = 0;
    always @(negedge clock) if (esc_pc === 1'b1) esc_count++;

    int checks   = 0;
    int failures = 0;
    int n_instr  = 0;
    logic [7:0] mpc;

    typedef struct {
        int         lat;
        int         rdy;
        logic       br;
        logic [7:0] alvo;
        logic [7:0] exp_next;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Entered with the DUT in its first request cycle; leaves it in the next
    // request cycle (or idle when hlt is set).
    task automatic run_instr(input int lat, input int rdy, input logic br,
                             input logic [7:0] alvo, input logic hlt,
                             input logic [7:0] exp_next);
        logic [15:0] d;
        d    = 16'($urandom);
        halt = hlt;
        chk("fetch_addr", mem_addr, mpc);
        for (int k = 0; k <= lat; k++) begin
            chk("req_held", mem_req, 1);
            chk("valid_low_in_fetch", instr_valid, 0);
            mem_ack  = (k == lat);
            mem_dado = (k == lat) ? d : ~d;
            tick();
        end
        mem_ack = 1'b0;
        for (int j = 0; j <= rdy; j++) begin
            chk("instr_valid", instr_valid, 1);
            chk("instr_data", instr, d);
            chk("req_dropped", mem_req, 0);
            chk("no_esc_in_deliver", esc_pc, 0);
            instr_ready = (j == rdy);
            desvio      = (j == rdy) ? br : 1'b1;
            alvo_desvio = (j == rdy) ? alvo : 8'($urandom);
            mem_ack     = (j != rdy);
            mem_dado    = ~d;
            tick();
        end
        instr_ready = 1'b0;
        desvio      = 1'b0;
        mem_ack     = 1'b0;
        chk("esc_pc_pulse", esc_pc, 1);
        chk("entrada_pc", entrada_pc, exp_next);
        chk("valid_low_in_update", instr_valid, 0);
        tick();
        n_instr++;
        chk("esc_pc_one_cycle", esc_pc, 0);
        chk("pc_written", pc_atual, exp_next);
        if (hlt) begin
            chk("halt_idle_req", mem_req, 0);
        end else begin
            chk("next_req", mem_req, 1);
            chk("next_addr", mem_addr, exp_next);
        end
        mpc = exp_next;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        reset = 1'b0; halt = 1'b1; mem_ack = 1'b0; mem_dado = '0;
        instr_ready = 1'b0; desvio = 1'b0; alvo_desvio = '0;
        pc_load = 1'b1; pc_load_val = 8'h00;

        tbl[0] = '{0,  0, 1'b0, 8'h00, 8'h01};
        tbl[1] = '{0,  0, 1'b1, 8'h3A, 8'h3A};
        tbl[2] = '{4,  3, 1'b0, 8'h00, 8'h3B};
        tbl[3] = '{1,  0, 1'b1, 8'h3B, 8'h3B};
        tbl[4] = '{14, 0, 1'b1, 8'hFF, 8'hFF};
        tbl[5] = '{0,  2, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{2,  1, 1'b0, 8'h00, 8'h01};
        tbl[7] = '{0,  0, 1'b1, 8'h00, 8'h00};

        tick(); tick();
        pc_load = 1'b0;
        chk("rst_entrada_pc", entrada_pc, 0);
        chk("rst_esc_pc", esc_pc, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_erro", erro_busca, 0);

        reset = 1'b1;
        tick();
        chk("idle_while_halt", mem_req, 0);
        halt = 1'b0;
        tick();
        chk("first_req", mem_req, 1);
        mpc = 8'h00;

        for (int i = 0; i < 8; i++)
            run_instr(tbl[i].lat, tbl[i].rdy, tbl[i].br, tbl[i].alvo, 1'b0, tbl[i].exp_next);

        // halt raised mid-fetch: instruction completes, then idle, then resume
        e = mpc + 8'd1;
        run_instr(2, 1, 1'b0, 8'h00, 1'b1, e);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_req", mem_req, 0);
            chk("halted_esc", esc_pc, 0);
        end
        halt = 1'b0;
        tick();
        chk("resume_req", mem_req, 1);
        chk("resume_addr", mem_addr, mpc);

        // asynchronous reset in the middle of a fetch
        tick();
        reset = 1'b0;
        mem_ack = 1'b1;
        #2;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_addr", mem_addr, 0);
        tick();
        mem_ack = 1'b0;
        chk("pc_kept_over_rst", pc_atual, mpc);
        reset = 1'b1;
        tick();
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, mpc);

        for (int i = 0; i < 60; i++) begin
            logic       br;
            logic [7:0] al;
            br = 1'($urandom);
            al = 8'($urandom);
            e  = br ? al : mpc + 8'd1;
            run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), br, al, 1'b0, e);
        end

        // timeout: 15 unanswered request cycles, then sticky error
        for (int k = 0; k < 15; k++) begin
            chk("timeout_req", mem_req, 1);
            chk("timeout_erro_low", erro_busca, 0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk("erro_sticky", erro_busca, 1);
            chk("erro_req", mem_req, 0);
            chk("erro_valid", instr_valid, 0);
            chk("erro_esc", esc_pc, 0);
            mem_ack = 1'b1;
            instr_ready = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        halt = 1'b1;
        reset = 1'b0;
        #2;
        chk("erro_cleared", erro_busca, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("erro_idle_req", mem_req, 0);
        halt = 1'b0;
        tick();
        chk("recover_req", mem_req, 1);
        chk("recover_addr", mem_addr, mpc);
        e = mpc + 8'd1;
        run_instr(0, 0, 1'b0, 8'h00, 1'b0, e);

        chk("esc_pc_total", esc_count, n_instr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
